// File: rtl/complex_acc.sv
// rtl/complex_acc.sv - frame accumulator for signed complex products with valid/ready output
//
// Purpose: sums LEN consecutive signed complex samples (in_re, in_im) into ACC_W-bit
// accumulators and presents one complex sum per frame on a valid/ready output register.
// Optional build macro: COMPLEX_ACC_SAT_EN (defined -> saturating adds, undefined -> wrap).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame restart (accumulators, count, frame ovf flag)
//   in_valid   input sample valid
//   in_ready   block can take a sample (combinational)
//   in_re      signed real part of product, IN_W bits
//   in_im      signed imaginary part of product, IN_W bits
//   out_valid  out_re/out_im/out_ovf hold a completed frame
//   out_ready  consumer accepts the pending frame
//   out_re     signed real frame sum, ACC_W bits
//   out_im     signed imaginary frame sum, ACC_W bits
//   out_ovf    at least one accumulator overflow happened during the frame
module complex_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int LEN   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_re,
  output logic signed [ACC_W-1:0] out_im,
  output logic                    out_ovf
);

  localparam int CW = $clog2(LEN + 1);
  localparam int SW = ACC_W + 1;

`ifdef COMPLEX_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // EMPTY: accumulating freely. FULL: holding an unread frame result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_re_q, acc_re_d;
  logic [ACC_W-1:0] acc_im_q, acc_im_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fovf_q, fovf_d;
  logic [ACC_W-1:0] out_re_q, out_re_d;
  logic [ACC_W-1:0] out_im_q, out_im_d;
  logic             out_ovf_q, out_ovf_d;

  logic             take;
  logic             out_xfer;
  logic             last;
  logic [ACC_W-1:0] base_re, base_im;
  logic [CW-1:0]    base_cnt;
  logic             base_fovf;
  logic [SW-1:0]    sum_re, sum_im;
  logic             ovf_re, ovf_im;
  logic [ACC_W-1:0] nxt_re, nxt_im;
  logic             frame_ovf;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign take      = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // clear acts as if the frame had just restarted, so a sample accepted in the same
  // cycle becomes the first sample of the new frame.
  assign base_re   = clear ? '0 : acc_re_q;
  assign base_im   = clear ? '0 : acc_im_q;
  assign base_cnt  = clear ? '0 : cnt_q;
  assign base_fovf = clear ? 1'b0 : fovf_q;

  // One guard bit above ACC_W: the top two bits disagree exactly when the true sum
  // falls outside the signed ACC_W range.
  assign sum_re = {base_re[ACC_W-1], base_re} + {{(SW-IN_W){in_re[IN_W-1]}}, in_re};
  assign sum_im = {base_im[ACC_W-1], base_im} + {{(SW-IN_W){in_im[IN_W-1]}}, in_im};
  assign ovf_re = sum_re[ACC_W] ^ sum_re[ACC_W-1];
  assign ovf_im = sum_im[ACC_W] ^ sum_im[ACC_W-1];

`ifdef COMPLEX_ACC_SAT_EN
  // Guard bit carries the true sign, which picks the rail to clamp to.
  assign nxt_re = ovf_re ? (sum_re[ACC_W] ? SAT_MIN : SAT_MAX) : sum_re[ACC_W-1:0];
  assign nxt_im = ovf_im ? (sum_im[ACC_W] ? SAT_MIN : SAT_MAX) : sum_im[ACC_W-1:0];
`else
  assign nxt_re = sum_re[ACC_W-1:0];
  assign nxt_im = sum_im[ACC_W-1:0];
`endif

  assign frame_ovf = base_fovf || ovf_re || ovf_im;
  assign last      = take && (base_cnt == CW'(LEN - 1));

  always_comb begin
    state_d   = state_q;
    acc_re_d  = base_re;
    acc_im_d  = base_im;
    cnt_d     = base_cnt;
    fovf_d    = base_fovf;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_ovf_d = out_ovf_q;

    if (take) begin
      if (last) begin
        out_re_d  = nxt_re;
        out_im_d  = nxt_im;
        out_ovf_d = frame_ovf;
        state_d   = ST_FULL;
        acc_re_d  = '0;
        acc_im_d  = '0;
        cnt_d     = '0;
        fovf_d    = 1'b0;
      end else begin
        acc_re_d  = nxt_re;
        acc_im_d  = nxt_im;
        cnt_d     = base_cnt + 1'b1;
        fovf_d    = frame_ovf;
      end
    end

    // A result loaded this cycle overrides the drain, so back-to-back frames have no bubble.
    if (!last && out_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      fovf_q    <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      cnt_q     <= cnt_d;
      fovf_q    <= fovf_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_re  = out_re_q;
  assign out_im  = out_im_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_complex_acc.sv
// tb/tb_complex_acc.sv - self-checking bench for complex_acc across four parameter sets
module tb_complex_acc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] in_re;
  logic signed [7:0] in_im;

  logic [3:0]         rdy, vld, ovf;
  logic signed [15:0] ore0, oim0, ore1, oim1, ore2, oim2;
  logic signed [9:0]  ore3, oim3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Shared stimulus, four configurations: LEN=4, LEN=2, LEN=1 (ACC_W=16) and LEN=16 (ACC_W=10).
  complex_acc #(.IN_W(8), .ACC_W(16), .LEN(4)) u_len4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_re(in_re), .in_im(in_im), .out_valid(vld[0]), .out_ready(out_ready),
    .out_re(ore0), .out_im(oim0), .out_ovf(ovf[0]));
  complex_acc #(.IN_W(8), .ACC_W(16), .LEN(2)) u_len2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_re(in_re), .in_im(in_im), .out_valid(vld[1]), .out_ready(out_ready),
    .out_re(ore1), .out_im(oim1), .out_ovf(ovf[1]));
  complex_acc #(.IN_W(8), .ACC_W(16), .LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_re(in_re), .in_im(in_im), .out_valid(vld[2]), .out_ready(out_ready),
    .out_re(ore2), .out_im(oim2), .out_ovf(ovf[2]));
  complex_acc #(.IN_W(8), .ACC_W(10), .LEN(16)) u_w10 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_re(in_re), .in_im(in_im), .out_valid(vld[3]), .out_ready(out_ready),
    .out_re(ore3), .out_im(oim3), .out_ovf(ovf[3]));

  // Reference model: the samples of the open frame are kept as a list and folded
  // into a sum only when the frame completes.
  int  ln[4] = '{4, 2, 1, 16};
  int  aw[4] = '{16, 16, 16, 10};
  bit  sat_en;
  bit  m_valid[4];
  int  m_ore[4], m_oim[4];
  bit  m_oovf[4];
  int  fcnt[4];
  int  fr_re[4][16], fr_im[4][16];

  typedef struct {
    bit v, r, c;
    int re, im;
    bit eir, ev;
    int ere, eim;
    bit eovf;
  } vec_t;

  vec_t tbl[19];

  function automatic int gre(input int k);
    case (k)
      0:       return int'(ore0);
      1:       return int'(ore1);
      2:       return int'(ore2);
      default: return int'(ore3);
    endcase
  endfunction

  function automatic int gim(input int k);
    case (k)
      0:       return int'(oim0);
      1:       return int'(oim1);
      2:       return int'(oim2);
      default: return int'(oim3);
    endcase
  endfunction

  function automatic vec_t mk(input bit v, r, c, input int re, im,
                              input bit eir, ev, input int ere, eim, input bit eovf);
    vec_t t;
    t.v = v; t.r = r; t.c = c; t.re = re; t.im = im;
    t.eir = eir; t.ev = ev; t.ere = ere; t.eim = eim; t.eovf = eovf;
    return t;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // Sum a frame's samples one at a time at ACC_W bits, with wrap or clamp on overflow.
  function automatic void fold(input int k, input bit use_im, output int res, output bit ov);
    int a  = 0;
    int mx = (1 << (aw[k] - 1)) - 1;
    int mn = -(1 << (aw[k] - 1));
    ov = 1'b0;
    for (int i = 0; i < fcnt[k]; i++) begin
      a += use_im ? fr_im[k][i] : fr_re[k][i];
      if (a > mx) begin
        ov = 1'b1;
        a  = sat_en ? mx : a - (1 << aw[k]);
      end else if (a < mn) begin
        ov = 1'b1;
        a  = sat_en ? mn : a + (1 << aw[k]);
      end
    end
    res = a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0; m_ore[k] = 0; m_oim[k] = 0; m_oovf[k] = 1'b0; fcnt[k] = 0;
    end
  endtask

  task automatic model_update();
    bit take, fin, ovr, ovi;
    int sr, si;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        m_valid[k] = 1'b0; m_ore[k] = 0; m_oim[k] = 0; m_oovf[k] = 1'b0; fcnt[k] = 0;
        continue;
      end
      take = in_valid && (!m_valid[k] || out_ready);
      fin  = 1'b0;
      if (clear) fcnt[k] = 0;
      if (take) begin
        fr_re[k][fcnt[k]] = int'(in_re);
        fr_im[k][fcnt[k]] = int'(in_im);
        fcnt[k]++;
        if (fcnt[k] == ln[k]) begin
          fold(k, 1'b0, sr, ovr);
          fold(k, 1'b1, si, ovi);
          m_ore[k] = sr; m_oim[k] = si; m_oovf[k] = ovr || ovi;
          m_valid[k] = 1'b1;
          fcnt[k] = 0;
          fin = 1'b1;
        end
      end
      if (!fin && m_valid[k] && out_ready) m_valid[k] = 1'b0;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m%0d_in_ready", k), int'(rdy[k]), int'(!m_valid[k] || out_ready));
      chk($sformatf("m%0d_out_valid", k), int'(vld[k]), int'(m_valid[k]));
      chk($sformatf("m%0d_out_re", k), gre(k), m_ore[k]);
      chk($sformatf("m%0d_out_im", k), gim(k), m_oim[k]);
      chk($sformatf("m%0d_out_ovf", k), int'(ovf[k]), int'(m_oovf[k]));
    end
  endtask

  // Drive at the falling edge, check model just after, then advance the model at the rising edge.
  task automatic step(input bit v, r, c, input int re, im, output logic [3:0] ir);
    @(negedge clk);
    in_valid = v; out_ready = r; clear = c;
    in_re = 8'(re); in_im = 8'(im);
    #1;
    ir = rdy;
    check_model();
    @(posedge clk);
    model_update();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), int'(vld[k]), 0);
      chk($sformatf("%s_re%0d", tag, k), gre(k), 0);
      chk($sformatf("%s_im%0d", tag, k), gim(k), 0);
      chk($sformatf("%s_ovf%0d", tag, k), int'(ovf[k]), 0);
    end
  endtask

  initial begin
    logic [3:0] ir;
    int nres;
    int e5re, e5im;

`ifdef COMPLEX_ACC_SAT_EN
    sat_en = 1'b1; e5re = 511;  e5im = -512;
`else
    sat_en = 1'b0; e5re = -16;  e5im = 0;
`endif

    // LEN=4 frames: basic sum, held result under back-pressure, clear with sample.
    tbl[0]  = mk(1,1,0,  1,  2, 1,0, 0, 0,0);
    tbl[1]  = mk(1,1,0,  3, -4, 1,0, 0, 0,0);
    tbl[2]  = mk(1,1,0, -5,  6, 1,0, 0, 0,0);
    tbl[3]  = mk(1,1,0,  7,  8, 1,1, 6,12,0);
    tbl[4]  = mk(0,1,0,  0,  0, 1,0, 6,12,0);
    tbl[5]  = mk(1,0,0,  1,  1, 1,0, 6,12,0);
    tbl[6]  = mk(1,0,0,  1,  1, 1,0, 6,12,0);
    tbl[7]  = mk(1,0,0,  1,  1, 1,0, 6,12,0);
    tbl[8]  = mk(1,0,0,  1,  1, 1,1, 4, 4,0);
    tbl[9]  = mk(1,0,0, 50, 50, 0,1, 4, 4,0);
    tbl[10] = mk(1,0,0, 50, 50, 0,1, 4, 4,0);
    tbl[11] = mk(0,1,0,  0,  0, 1,0, 4, 4,0);
    tbl[12] = mk(1,1,0, 10, 10, 1,0, 4, 4,0);
    tbl[13] = mk(1,1,0, 10, 10, 1,0, 4, 4,0);
    tbl[14] = mk(1,1,1,  1, -1, 1,0, 4, 4,0);
    tbl[15] = mk(1,1,0,  1,  1, 1,0, 4, 4,0);
    tbl[16] = mk(1,1,0,  1,  1, 1,0, 4, 4,0);
    tbl[17] = mk(1,1,0,  1,  1, 1,1, 4, 2,0);
    tbl[18] = mk(0,1,0,  0,  0, 1,0, 4, 2,0);

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].re, tbl[i].im, ir);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), int'(ir[0]), int'(tbl[i].eir));
      chk($sformatf("tbl%0d_out_valid", i), int'(vld[0]), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_out_re", i), gre(0), tbl[i].ere);
      chk($sformatf("tbl%0d_out_im", i), gim(0), tbl[i].eim);
      chk($sformatf("tbl%0d_out_ovf", i), int'(ovf[0]), int'(tbl[i].eovf));
    end

    // LEN=2 streaming (-128,-128): a result every second cycle, input never stalls.
    step(0, 1, 1, 0, 0, ir);
    nres = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, -128, -128, ir);
      #1;
      chk($sformatf("len2_in_ready%0d", i), int'(ir[1]), 1);
      chk($sformatf("len2_valid%0d", i), int'(vld[1]), int'(i % 2 == 0));
      if (vld[1]) begin
        nres++;
        chk($sformatf("len2_re%0d", i), gre(1), -256);
        chk($sformatf("len2_im%0d", i), gim(1), -256);
      end
    end
    chk("len2_result_count", nres, 4);

    // LEN=1: each accepted sample is its own frame, including one taken with clear.
    step(1, 1, 0, 5, -3, ir);  #1;
    chk("len1_a_valid", int'(vld[2]), 1); chk("len1_a_re", gre(2), 5); chk("len1_a_im", gim(2), -3);
    step(1, 1, 0, 7, 9, ir);   #1;
    chk("len1_b_valid", int'(vld[2]), 1); chk("len1_b_re", gre(2), 7); chk("len1_b_im", gim(2), 9);
    step(1, 1, 1, 2, 2, ir);   #1;
    chk("len1_clr_valid", int'(vld[2]), 1); chk("len1_clr_re", gre(2), 2); chk("len1_clr_im", gim(2), 2);

    // ACC_W=10, LEN=16: accumulator overflow on both parts.
    step(0, 1, 1, 0, 0, ir);
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 0, 127, -128, ir);
      #1;
      if (i < 16) chk($sformatf("w10_valid%0d", i), int'(vld[3]), 0);
    end
    chk("w10_final_valid", int'(vld[3]), 1);
    chk("w10_final_re", gre(3), e5re);
    chk("w10_final_im", gim(3), e5im);
    chk("w10_final_ovf", int'(ovf[3]), 1);

    // Asynchronous reset mid-frame and while a result is pending.
    step(0, 1, 1, 0, 0, ir);
    step(1, 1, 0, 9, 9, ir);
    step(1, 1, 0, 9, 9, ir);
    step(1, 0, 0, 3, 3, ir);
    #1;
    chk("prerst_len1_valid", int'(vld[2]), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 2, 1, ir);
    #1;
    chk("postrst_valid", int'(vld[0]), 1);
    chk("postrst_re", gre(0), 8);
    chk("postrst_im", gim(0), 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, ir);
    end
    step(0, 1, 0, 0, 0, ir);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
